// File: rtl/reg_access_ctrl.sv
// Register-file access controller: turns write-fill and read-burst commands
// into single-cycle register-file strobes and a read response stream.
module reg_access_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_wr,
    input  logic [1:0] cmd_addr,
    input  logic [1:0] cmd_len,
    input  logic [7:0] cmd_wdata,
    output logic       rf_w_en,
    output logic       rf_r_en,
    output logic [1:0] rf_addr,
    output logic [7:0] rf_wdata,
    input  logic [7:0] rf_rdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_last,
    output logic       busy,
    output logic [1:0] dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both 1; the offering side holds its payload stable until that edge, and
    // ready never depends combinationally on valid.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RSP  = 2'd3
    } state_t;

    state_t     state, state_nx;
    logic [1:0] cur_addr, cur_addr_nx;
    logic [1:0] beat_cnt, beat_cnt_nx;
    logic [7:0] wdata_q, wdata_nx;
    logic [7:0] rsp_data_q, rsp_data_nx;
    logic       rsp_valid_q, rsp_valid_nx;
    logic       rsp_last_q, rsp_last_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cur_addr    <= 2'd0;
            beat_cnt    <= 2'd0;
            wdata_q     <= 8'd0;
            rsp_data_q  <= 8'd0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            state       <= state_nx;
            cur_addr    <= cur_addr_nx;
            beat_cnt    <= beat_cnt_nx;
            wdata_q     <= wdata_nx;
            rsp_data_q  <= rsp_data_nx;
            rsp_valid_q <= rsp_valid_nx;
            rsp_last_q  <= rsp_last_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cur_addr_nx  = cur_addr;
        beat_cnt_nx  = beat_cnt;
        wdata_nx     = wdata_q;
        rsp_data_nx  = rsp_data_q;
        rsp_valid_nx = rsp_valid_q;
        rsp_last_nx  = rsp_last_q;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    cur_addr_nx = cmd_addr;
                    beat_cnt_nx = cmd_len;
                    wdata_nx    = cmd_wdata;
                    state_nx    = cmd_wr ? WR : RD;
                end
            end
            WR: begin
                if (beat_cnt == 2'd0) begin
                    state_nx = IDLE;
                end else begin
                    cur_addr_nx = cur_addr + 2'd1;
                    beat_cnt_nx = beat_cnt - 2'd1;
                end
            end
            RD: begin
                rsp_data_nx  = rf_rdata;
                rsp_valid_nx = 1'b1;
                rsp_last_nx  = (beat_cnt == 2'd0);
                state_nx     = RSP;
            end
            RSP: begin
                // The next register read is only issued once this beat is consumed.
                if (rsp_ready) begin
                    rsp_valid_nx = 1'b0;
                    if (rsp_last_q) begin
                        state_nx = IDLE;
                    end else begin
                        cur_addr_nx = cur_addr + 2'd1;
                        beat_cnt_nx = beat_cnt - 2'd1;
                        state_nx    = RD;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // All register-file strobes are decoded from registered state only.
    assign cmd_ready = (state == IDLE) && rst;
    assign rf_w_en   = (state == WR);
    assign rf_r_en   = (state == RD);
    assign rf_addr   = (state == WR || state == RD) ? cur_addr : 2'd0;
    assign rf_wdata  = (state == WR) ? wdata_q : 8'd0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_last  = rsp_last_q;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Bench for reg_access_ctrl: register file stub, transaction-level model,
// per-cycle compare process, directed cases and randomized command traffic.
module tb_reg_access_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rf_init = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_wr = 1'b0;
    logic [1:0] cmd_addr = 2'd0;
    logic [1:0] cmd_len = 2'd0;
    logic [7:0] cmd_wdata = 8'd0;
    logic       rf_w_en, rf_r_en;
    logic [1:0] rf_addr;
    logic [7:0] rf_wdata, rf_rdata;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data;
    logic       rsp_last;
    logic       busy;
    logic [1:0] dbg_state;

    logic       rr_random = 1'b0;
    logic       rr_fixed = 1'b1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] rf [4];
    logic [9:0] wr_log [$];
    logic [8:0] rsp_log [$];
    int         rsp_cyc [$];
    int         busy_cnt = 0;

    reg_access_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_wdata (cmd_wdata),
        .rf_w_en   (rf_w_en),
        .rf_r_en   (rf_r_en),
        .rf_addr   (rf_addr),
        .rf_wdata  (rf_wdata),
        .rf_rdata  (rf_rdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rf_init) begin
            rf[0] <= 8'h11;
            rf[1] <= 8'h22;
            rf[2] <= 8'h33;
            rf[3] <= 8'h44;
        end else if (rf_w_en) begin
            rf[rf_addr] <= rf_wdata;
        end
    end
    assign rf_rdata = rf_r_en ? rf[rf_addr] : 8'h00;

    initial forever begin
        @(posedge clk);
        #2;
        rsp_ready = rr_random ? 1'($urandom_range(0, 1)) : rr_fixed;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: remaining write beats, remaining read beats,
    // whether this cycle must be a register read, and whether a response is owed.
    initial begin : compare
        logic [7:0] mrf [4];
        logic [8:0] exp_q [$];
        int         w_left, rd_left;
        logic [1:0] w_addr, r_addr, a;
        logic [7:0] w_data;
        logic       rd_now, hold, m_busy;
        w_left = 0; rd_left = 0; rd_now = 0; hold = 0;
        w_addr = 0; r_addr = 0; w_data = 0;
        mrf[0] = 8'h11; mrf[1] = 8'h22; mrf[2] = 8'h33; mrf[3] = 8'h44;
        forever begin
            @(negedge clk);
            if (rf_init) begin
                mrf[0] = 8'h11; mrf[1] = 8'h22; mrf[2] = 8'h33; mrf[3] = 8'h44;
            end
            if (!rst) begin
                chk("rst_cmd_ready", 32'(cmd_ready), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_rf_w_en", 32'(rf_w_en), 0);
                chk("rst_rf_r_en", 32'(rf_r_en), 0);
                chk("rst_rsp_valid", 32'(rsp_valid), 0);
                chk("rst_rsp_last", 32'(rsp_last), 0);
                chk("rst_rsp_data", 32'(rsp_data), 0);
                w_left = 0; rd_left = 0; rd_now = 0; hold = 0;
                exp_q.delete();
            end else begin
                m_busy = (w_left > 0) || (rd_left > 0);
                chk("busy", 32'(busy), 32'(m_busy));
                chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
                chk("rf_w_en", 32'(rf_w_en), 32'(w_left > 0));
                chk("rf_r_en", 32'(rf_r_en), 32'(rd_now));
                chk("rf_addr", 32'(rf_addr), (w_left > 0) ? 32'(w_addr) : (rd_now ? 32'(r_addr) : 0));
                chk("rf_wdata", 32'(rf_wdata), (w_left > 0) ? 32'(w_data) : 0);
                chk("rsp_valid", 32'(rsp_valid), 32'(hold));
                if (hold && exp_q.size() > 0)
                    chk("rsp_beat", 32'({rsp_last, rsp_data}), 32'(exp_q[0]));
                if (rf_w_en) wr_log.push_back({rf_addr, rf_wdata});
                if (rsp_valid && rsp_ready) begin
                    rsp_log.push_back({rsp_last, rsp_data});
                    rsp_cyc.push_back(cyc);
                end
                if (busy) busy_cnt++;
                if (w_left > 0) begin
                    mrf[w_addr] = w_data;
                    w_addr = w_addr + 2'd1;
                    w_left--;
                end
                if (rd_now) begin
                    rd_now = 0;
                    hold = 1;
                end else if (hold && rsp_ready) begin
                    hold = 0;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    rd_left--;
                    if (rd_left > 0) begin
                        rd_now = 1;
                        r_addr = r_addr + 2'd1;
                    end
                end
                if (!m_busy && cmd_valid) begin
                    if (cmd_wr) begin
                        w_left = int'(cmd_len) + 1;
                        w_addr = cmd_addr;
                        w_data = cmd_wdata;
                    end else begin
                        rd_left = int'(cmd_len) + 1;
                        rd_now = 1;
                        r_addr = cmd_addr;
                        for (int i = 0; i <= int'(cmd_len); i++) begin
                            a = cmd_addr + 2'(i);
                            exp_q.push_back({(i == int'(cmd_len)), mrf[a]});
                        end
                    end
                end
            end
        end
    end

    task automatic send_cmd(input logic wr, input logic [1:0] addr, input logic [1:0] len,
                            input logic [7:0] data);
        logic acc;
        acc = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_len = len; cmd_wdata = data;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("cmd_accept_timeout", 0, 1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            done = !busy && !rsp_valid;
        end
        if (!done) chk("idle_timeout", 0, 1);
    endtask

    task automatic clear_logs();
        wr_log.delete();
        rsp_log.delete();
        rsp_cyc.delete();
        busy_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cnt;
        logic [7:0] d;
        // Power-on reset, register file loaded with 11/22/33/44.
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("por_cmd_ready", 32'(cmd_ready), 0);
        rf_init = 1'b0;
        #1;
        rst = 1'b1;

        // Two-beat read from address 1 with the consumer always ready.
        clear_logs();
        send_cmd(1'b0, 2'd1, 2'd1, 8'h00);
        wait_idle();
        chk("rd2_count", 32'(rsp_log.size()), 2);
        if (rsp_log.size() == 2) begin
            chk("rd2_beat0", 32'(rsp_log[0]), 32'h022);
            chk("rd2_beat1", 32'(rsp_log[1]), 32'h133);
            chk("rd2_spacing", 32'(rsp_cyc[1] - rsp_cyc[0]), 2);
        end

        // Back-pressured single read of address 3.
        clear_logs();
        rr_fixed = 1'b0;
        send_cmd(1'b0, 2'd3, 2'd0, 8'h00);
        cnt = 0;
        for (int n = 0; n < 20 && !rsp_valid; n++) @(negedge clk);
        chk("bp_valid_seen", 32'(rsp_valid), 1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_data", 32'(rsp_data), 32'h44);
            chk("bp_hold_ready", 32'(cmd_ready), 0);
            if (rf_r_en) cnt++;
        end
        chk("bp_no_reads", 32'(cnt), 0);
        @(posedge clk);
        #1;
        rr_fixed = 1'b1;
        wait_idle();
        chk("bp_done_count", 32'(rsp_log.size()), 1);

        // Single write.
        clear_logs();
        send_cmd(1'b1, 2'd2, 2'd0, 8'hA5);
        wait_idle();
        chk("w1_count", 32'(wr_log.size()), 1);
        if (wr_log.size() == 1) chk("w1_beat", 32'(wr_log[0]), 32'h2A5);
        chk("w1_busy", 32'(busy_cnt), 1);

        // Four-beat write wrapping 3 -> 0.
        clear_logs();
        send_cmd(1'b1, 2'd3, 2'd3, 8'h5A);
        wait_idle();
        chk("w4_count", 32'(wr_log.size()), 4);
        if (wr_log.size() == 4) begin
            chk("w4_beat0", 32'(wr_log[0]), 32'h35A);
            chk("w4_beat1", 32'(wr_log[1]), 32'h05A);
            chk("w4_beat2", 32'(wr_log[2]), 32'h15A);
            chk("w4_beat3", 32'(wr_log[3]), 32'h25A);
        end
        chk("w4_busy", 32'(busy_cnt), 4);
        chk("w4_ready_back", 32'(cmd_ready), 1);

        // cmd_valid held with changing fields during a four-beat write.
        clear_logs();
        send_cmd(1'b1, 2'd0, 2'd3, 8'hC3);
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            cmd_wr = 1'($urandom_range(0, 1));
            cmd_addr = 2'($urandom_range(0, 3));
            cmd_len = 2'($urandom_range(0, 3));
            cmd_wdata = 8'($urandom_range(0, 255));
        end
        send_cmd(1'b0, 2'd0, 2'd0, 8'h00);
        wait_idle();
        chk("hold_w_count", 32'(wr_log.size()), 4);
        if (wr_log.size() == 4) chk("hold_w_last", 32'(wr_log[3]), 32'h3C3);
        chk("hold_rsp_count", 32'(rsp_log.size()), 1);
        if (rsp_log.size() == 1) chk("hold_rsp", 32'(rsp_log[0]), 32'h1C3);

        // Asynchronous reset during beat 2 of a four-beat read.
        clear_logs();
        send_cmd(1'b0, 2'd0, 2'd3, 8'h00);
        cnt = 0;
        for (int n = 0; n < 40 && cnt < 2; n++) begin
            @(negedge clk);
            if (rf_r_en) cnt++;
        end
        chk("ar_beat2_seen", 32'(cnt), 2);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_rf_r_en", 32'(rf_r_en), 0);
        chk("ar_rf_addr", 32'(rf_addr), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_rsp_valid", 32'(rsp_valid), 0);
        chk("ar_cmd_ready", 32'(cmd_ready), 0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("ar_no_rsp", 32'(rsp_valid), 0);
        end

        // Randomized traffic with random consumer back-pressure.
        rr_random = 1'b1;
        for (int n = 0; n < 40; n++) begin
            d = 8'($urandom_range(0, 255));
            send_cmd(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     2'($urandom_range(0, 3)), d);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end
        rr_random = 1'b0;
        rr_fixed = 1'b1;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
